// File: rtl/uart_line_echo_pkg.sv
// Shared constants and state encoding for the line echo engine.
package uart_line_echo_pkg;

  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_PROMPT,
    S_BODY,
    S_EOL_CR,
    S_EOL_LF
  } echo_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_line_echo_buf.sv
// Line storage: register array with a single write port and a combinational read port.
module uart_line_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_line_echo.sv
// Line echo engine: collects an edited line, then replays prompt + line + CR LF.
// States: COLLECT (gather rx), PROMPT, BODY, EOL_CR, EOL_LF (one byte per handshake).
module uart_line_echo
  import uart_line_echo_pkg::*;
#(
  parameter int BUF_DEPTH  = 64,
  parameter int PROMPT_LEN = 6,
  parameter logic [((PROMPT_LEN > 0) ? PROMPT_LEN : 1)*8-1:0] PROMPT = "echo> ",
  parameter logic [7:0] EOL_CHAR = ASCII_CR,
  parameter bit BS_EN = 1'b1,
  localparam int LW = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic [LW-1:0] line_len,
  output logic          overflow,
  output logic          dropped
);

  localparam int IW  = $clog2(max_int(BUF_DEPTH, PROMPT_LEN));
  localparam int BAW = $clog2(BUF_DEPTH);
  localparam int PW  = ((PROMPT_LEN > 0) ? PROMPT_LEN : 1) * 8;
  localparam logic [IW-1:0] PROMPT_LAST = IW'((PROMPT_LEN > 0) ? PROMPT_LEN - 1 : 0);
  localparam logic [LW-1:0] DEPTH_L = LW'(BUF_DEPTH);

  echo_state_t    state, state_next, after_prompt;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  body_last;
  logic [PW-1:0]  prompt_sh;
  logic [7:0]     send_byte, buf_rd;
  logic [BAW-1:0] buf_waddr, buf_raddr;
  logic           accept, load;
  logic           is_eol, is_lf, is_bs;
  logic           do_store, do_bs, do_overflow;

  assign busy      = (state != S_COLLECT);
  assign body_last = IW'(line_len - LW'(1));
  assign prompt_sh = PROMPT << {idx, 3'b000};
  assign buf_waddr = line_len[BAW-1:0];
  assign buf_raddr = idx[BAW-1:0];

  uart_line_buf #(
    .DEPTH (BUF_DEPTH),
    .AW    (BAW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (do_store),
    .wr_addr (buf_waddr),
    .wr_data (rx_data),
    .rd_addr (buf_raddr),
    .rd_data (buf_rd)
  );

  always_comb begin
    state_next   = state;
    after_prompt = (line_len == '0) ? S_EOL_CR : S_BODY;
    is_eol       = (rx_data == EOL_CHAR);
    is_lf        = (rx_data == ASCII_LF);
    is_bs        = BS_EN && ((rx_data == ASCII_BS) || (rx_data == ASCII_DEL));
    do_store     = 1'b0;
    do_bs        = 1'b0;
    do_overflow  = 1'b0;
    send_byte    = 8'h00;
    accept       = tx_valid && tx_ready;
    case (state)
      S_COLLECT: begin
        if (rx_valid) begin
          if (is_eol) begin
            state_next = (PROMPT_LEN > 0) ? S_PROMPT : after_prompt;
          end else if (!is_lf) begin
            if (is_bs)                     do_bs       = (line_len != '0);
            else if (line_len < DEPTH_L)   do_store    = 1'b1;
            else                           do_overflow = 1'b1;
          end
        end
      end
      S_PROMPT: begin
        send_byte = prompt_sh[PW-1 -: 8];
        if (accept && idx == PROMPT_LAST) state_next = after_prompt;
      end
      S_BODY: begin
        send_byte = buf_rd;
        if (accept && idx == body_last) state_next = S_EOL_CR;
      end
      S_EOL_CR: begin
        send_byte = ASCII_CR;
        if (accept) state_next = S_EOL_LF;
      end
      S_EOL_LF: begin
        send_byte = ASCII_LF;
        if (accept) state_next = S_COLLECT;
      end
      default: state_next = S_COLLECT;
    endcase
    // One idle cycle with tx_valid low precedes every byte in a send state.
    load = busy && !tx_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_COLLECT;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_len <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      overflow <= do_overflow;
      dropped  <= rx_valid && busy;
      if (do_store)                           line_len <= line_len + LW'(1);
      else if (do_bs)                         line_len <= line_len - LW'(1);
      else if (accept && state == S_EOL_LF)   line_len <= '0;
      if (accept) begin
        tx_valid <= 1'b0;
        idx      <= (state_next == state) ? idx + IW'(1) : '0;
      end else if (load) begin
        tx_valid <= 1'b1;
        tx_data  <= send_byte;
      end
    end
  end

endmodule

// File: tb/tb_uart_line_echo.sv
// Randomized and directed bench for uart_line_echo against a queue-based line model.
`timescale 1ns/1ps
module tb_uart_line_echo;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic [LW-1:0] line_len;
  logic          overflow;
  logic          dropped;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int dut_ov = 0;
  int dut_drop = 0;

  logic [7:0] m_line[$];
  logic [7:0] m_exp[$];
  logic [7:0] got[$];
  bit         m_ov = 1'b0;
  bit         m_drop = 1'b0;
  string      prompt_s = "echo> ";

  logic       pv = 1'b0, pacc = 1'b0, pbusy = 1'b0;
  logic [7:0] pd = 8'h00;

  uart_line_echo #(.BUF_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .line_len (line_len),
    .overflow (overflow),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 2) != 0);
      default: tx_ready = 1'b0;
    endcase
  end

  // Line model: what a terminal user expects to see echoed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_line.delete();
      m_exp.delete();
      m_ov   = 1'b0;
      m_drop = 1'b0;
    end else begin
      m_ov   = 1'b0;
      m_drop = 1'b0;
      if (rx_valid) begin
        if (m_exp.size() != 0) m_drop = 1'b1;
        else if (rx_data == 8'h0D) begin
          for (int i = 0; i < prompt_s.len(); i++) m_exp.push_back(prompt_s[i]);
          foreach (m_line[i]) m_exp.push_back(m_line[i]);
          m_exp.push_back(8'h0D);
          m_exp.push_back(8'h0A);
        end else if (rx_data == 8'h0A) begin
          m_drop = 1'b0;
        end else if (rx_data == 8'h08 || rx_data == 8'h7F) begin
          if (m_line.size() > 0) void'(m_line.pop_back());
        end else if (m_line.size() < DEPTH) m_line.push_back(rx_data);
        else m_ov = 1'b1;
      end
      if (tx_valid && tx_ready && m_exp.size() != 0) begin
        got.push_back(tx_data);
        void'(m_exp.pop_front());
        if (m_exp.size() == 0) m_line.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0; pacc = 1'b0; pbusy = 1'b0;
    end else begin
      chk("busy", busy, m_exp.size() != 0);
      chk("line_len", line_len, m_line.size());
      chk("overflow", overflow, m_ov);
      chk("dropped", dropped, m_drop);
      if (overflow) dut_ov++;
      if (dropped)  dut_drop++;
      if (!busy) chk("idle_tx_valid", tx_valid, 0);
      if (pacc) chk("gap_after_accept", tx_valid, 0);
      else if (pv) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, pd);
      end else if (pbusy) chk("rise_after_gap", tx_valid, 1);
      if (tx_valid && tx_ready) begin
        if (m_exp.size() == 0) chk("tx_when_nothing_due", tx_valid, 0);
        else chk("tx_data", tx_data, m_exp[0]);
      end
      pv = tx_valid; pd = tx_data; pacc = tx_valid && tx_ready; pbusy = busy;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic rx_str(input string s);
    for (int i = 0; i < s.len(); i++) rx_byte(s[i]);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((busy || m_exp.size() != 0) && k < budget) begin @(posedge clk); #1; k++; end
    chk("wait_done_timeout", busy || m_exp.size() != 0, 0);
  endtask

  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin @(posedge clk); #1; k++; end
    chk("wait_got_timeout", got.size() >= n, 1);
  endtask

  task automatic check_line(input string body);
    string s;
    s = {prompt_s, body};
    chk("got_len", got.size(), s.len() + 2);
    for (int i = 0; i < s.len() && i < got.size(); i++)
      chk($sformatf("got[%0d]", i), got[i], s[i]);
    if (got.size() >= s.len() + 2) begin
      chk("got_cr", got[s.len()], 8'h0D);
      chk("got_lf", got[s.len() + 1], 8'h0A);
    end
    got.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ov0, dd, k, r;
    logic [7:0] b;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_len", line_len, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropped", dropped, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    rx_byte(8'h08); idle(1);
    chk("bs_empty_len", line_len, 0);

    rx_str("hi");
    chk("len_hi", line_len, 2);
    rx_byte(8'h0D);
    wait_done(200);
    check_line("hi");
    chk("after_line_len", line_len, 0);
    chk("after_busy", busy, 0);

    rx_str("abc"); rx_byte(8'h08); rx_str("d"); rx_byte(8'h0D);
    wait_done(200);
    check_line("abd");

    ov0 = dut_ov;
    rx_str("abcdef");
    chk("len_full", line_len, 4);
    rx_byte(8'h0D);
    wait_done(200);
    chk("overflow_pulses", dut_ov - ov0, 2);
    check_line("abcd");

    rx_byte(8'h0D);
    wait_done(200);
    check_line("");
    rx_byte(8'h0D); rx_byte(8'h0A);
    wait_done(200);
    idle(10);
    check_line("");

    rx_str("wxyz"); rx_byte(8'h0D);
    wait_got(8, 200);
    ready_mode = 2;
    idle(3);
    dd = dut_drop;
    rx_byte("q");
    idle(20);
    chk("stall_dropped", dut_drop - dd, 1);
    chk("stall_valid", tx_valid, 1);
    ready_mode = 0;
    wait_done(200);
    check_line("wxyz");

    rx_str("mnop"); rx_byte(8'h0D);
    wait_got(7, 200);
    k = 0;
    while (!tx_valid && k < 10) begin @(posedge clk); #1; k++; end
    chk("mid_body_valid", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_line_len", line_len, 0);
    chk("abort_busy", busy, 0);
    idle(3);
    rst_n = 1'b1;
    got.delete();
    idle(2);
    rx_byte("x"); rx_byte(8'h0D);
    wait_done(200);
    check_line("x");

    ready_mode = 1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 15);
      if (r < 2)       b = 8'h0D;
      else if (r == 2) b = 8'h0A;
      else if (r == 3) b = 8'h08;
      else if (r == 4) b = 8'h7F;
      else             b = 8'h61 + 8'($urandom_range(0, 25));
      rx_byte(b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end
    wait_done(500);
    got.delete();
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
